// File: rtl/filtros_pkg.sv
// Shared definitions for the filter-block register interface.
// Frame length depends on MAESTRO_REGISTROS_CHECKSUM_EN (adds a trailing XOR byte).
package filtros_pkg;

    typedef enum logic [1:0] {
        ESPERA  = 2'd0,
        RECIBE  = 2'd1,
        ESCRIBE = 2'd2
    } estado_t;

`ifdef MAESTRO_REGISTROS_CHECKSUM_EN
    localparam int BYTES_TRAMA = 6;
`else
    localparam int BYTES_TRAMA = 5;
`endif

    localparam int ANCHO_DIR_DEF  = 11;
    localparam int ANCHO_DATO_DEF = 21;

endpackage

// File: rtl/temporizador_espera.sv
// Idle counter for stream receivers: counts enabled cycles since the last clear
// and flags expiry at TIEMPO_ESPERA-1.
module temporizador_espera #(
    parameter int TIEMPO_ESPERA = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic limpiar,
    input  logic habilitar,
    output logic expirado
);

    logic [15:0] cuenta;

    assign expirado = (cuenta == 16'(TIEMPO_ESPERA - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cuenta <= '0;
        end else if (limpiar) begin
            cuenta <= '0;
        end else if (habilitar && !expirado) begin
            cuenta <= cuenta + 16'd1;
        end
    end

endmodule

// File: rtl/maestro_registros.sv
// Register-bus master: assembles byte-stream frames into single-cycle register writes.
// Optional MAESTRO_REGISTROS_CHECKSUM_EN appends and verifies an XOR checksum byte.
import filtros_pkg::*;

module maestro_registros #(
    parameter int ANCHO_DIR     = ANCHO_DIR_DEF,
    parameter int ANCHO_DATO    = ANCHO_DATO_DEF,
    parameter int TIEMPO_ESPERA = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            dato_entrada,
    input  logic                  dato_valido,
    output logic                  dato_listo,
    output logic [ANCHO_DIR-1:0]  direccion_registros,
    output logic [ANCHO_DATO-1:0] datos_registros,
    output logic                  habilitacion_registros,
    output logic                  error_trama,
    output logic [15:0]           contador_escrituras
);

    localparam int ANCHO_IDX = $clog2(BYTES_TRAMA);

    estado_t estado, estado_sig;

    logic                  listo_q;
    logic [ANCHO_IDX-1:0]  indice;
    logic [7:0]            buffer [BYTES_TRAMA-1];
    logic [7:0]            b [5];
    logic                  acepta;
    logic                  ultimo;
    logic                  chk_ok;
    logic                  expirado;
    logic [ANCHO_DIR-1:0]  dir_q;
    logic [ANCHO_DATO-1:0] dato_q;
    logic                  error_q;
    logic [15:0]           contador_q;

    assign acepta = dato_valido && listo_q;
    assign ultimo = (indice == ANCHO_IDX'(BYTES_TRAMA - 1));

    // The final byte is never stored: it is taken straight from dato_entrada.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            b[i] = buffer[i];
        end
`ifdef MAESTRO_REGISTROS_CHECKSUM_EN
        b[4]   = buffer[4];
        chk_ok = ((b[0] ^ b[1] ^ b[2] ^ b[3] ^ b[4]) == dato_entrada);
`else
        b[4]   = dato_entrada;
        chk_ok = 1'b1;
`endif
    end

    temporizador_espera #(
        .TIEMPO_ESPERA(TIEMPO_ESPERA)
    ) u_temporizador (
        .clk      (clk),
        .reset    (reset),
        .limpiar  (acepta || (estado != RECIBE)),
        .habilitar(estado == RECIBE),
        .expirado (expirado)
    );

    // State register; dato_listo is registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado  <= ESPERA;
            listo_q <= 1'b0;
        end else begin
            estado  <= estado_sig;
            listo_q <= (estado_sig != ESCRIBE);
        end
    end

    always_comb begin
        estado_sig = estado;
        case (estado)
            ESPERA: begin
                if (acepta) begin
                    estado_sig = RECIBE;
                end
            end
            RECIBE: begin
                if (acepta) begin
                    if (ultimo) begin
                        estado_sig = chk_ok ? ESCRIBE : ESPERA;
                    end
                end else if (expirado) begin
                    estado_sig = ESPERA;
                end
            end
            ESCRIBE: estado_sig = ESPERA;
            default: estado_sig = ESPERA;
        endcase
    end

    always_comb begin
        habilitacion_registros = (estado == ESCRIBE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            indice     <= '0;
            dir_q      <= '0;
            dato_q     <= '0;
            error_q    <= 1'b0;
            contador_q <= '0;
            for (int unsigned i = 0; i < BYTES_TRAMA - 1; i++) begin
                buffer[i] <= '0;
            end
        end else begin
            error_q <= 1'b0;
            if (acepta) begin
                if (ultimo) begin
                    indice <= '0;
                    if (chk_ok) begin
                        dir_q  <= ANCHO_DIR'({b[0], b[1]});
                        dato_q <= ANCHO_DATO'({b[2], b[3], b[4]});
                    end else begin
                        error_q <= 1'b1;
                    end
                end else begin
                    indice <= indice + ANCHO_IDX'(1);
                    for (int unsigned i = 0; i < BYTES_TRAMA - 1; i++) begin
                        if (indice == ANCHO_IDX'(i)) begin
                            buffer[i] <= dato_entrada;
                        end
                    end
                end
            end else if (estado == RECIBE && expirado) begin
                indice  <= '0;
                error_q <= 1'b1;
            end
            if (estado == ESCRIBE) begin
                contador_q <= contador_q + 16'd1;
            end
        end
    end

    assign dato_listo          = listo_q;
    assign direccion_registros = dir_q;
    assign datos_registros     = dato_q;
    assign error_trama         = error_q;
    assign contador_escrituras = contador_q;

endmodule

// File: tb/tb_maestro_registros.sv
// Directed self-checking bench for maestro_registros (both frame formats).
module tb_maestro_registros;

    localparam int T = 8;
`ifdef MAESTRO_REGISTROS_CHECKSUM_EN
    localparam int NB = 6;
`else
    localparam int NB = 5;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  dato_entrada;
    logic        dato_valido;
    logic        dato_listo;
    logic [10:0] direccion_registros;
    logic [20:0] datos_registros;
    logic        habilitacion_registros;
    logic        error_trama;
    logic [15:0] contador_escrituras;

    int checks = 0;
    int failures = 0;
    int n_strobe = 0;
    int n_err = 0;
    int ciclo = 0;
    int t_prev = -1;
    int sep = 0;
    int exp_cnt = 0;

    maestro_registros #(
        .ANCHO_DIR(11),
        .ANCHO_DATO(21),
        .TIEMPO_ESPERA(T)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .dato_entrada          (dato_entrada),
        .dato_valido           (dato_valido),
        .dato_listo            (dato_listo),
        .direccion_registros   (direccion_registros),
        .datos_registros       (datos_registros),
        .habilitacion_registros(habilitacion_registros),
        .error_trama           (error_trama),
        .contador_escrituras   (contador_escrituras)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ciclo++;

    always @(negedge clk) begin
        if (habilitacion_registros === 1'b1) begin
            n_strobe++;
            if (t_prev >= 0) sep = ciclo - t_prev;
            t_prev = ciclo;
        end
        if (error_trama === 1'b1) n_err++;
    end

    task automatic send_byte(input logic [7:0] v);
        logic ok;
        int espera;
        dato_entrada = v;
        dato_valido  = 1'b1;
        ok = 1'b0;
        espera = 0;
        while (!ok && espera < 20) begin
            ok = (dato_listo === 1'b1);
            @(posedge clk);
            #1;
            espera++;
        end
        dato_valido = 1'b0;
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL accept_byte: byte %02h not accepted within 20 cycles, got=%b required=1", v, ok);
        end
    endtask

    task automatic send_frame(input logic [7:0] b0, b1, b2, b3, b4);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        send_byte(b3);
        send_byte(b4);
`ifdef MAESTRO_REGISTROS_CHECKSUM_EN
        send_byte(b0 ^ b1 ^ b2 ^ b3 ^ b4);
`endif
    endtask

    task automatic test_reset;
        reset = 1'b1;
        dato_valido = 1'b0;
        dato_entrada = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (dato_listo !== 1'b0) begin failures++; $display("FAIL reset_listo: got=%b required=0", dato_listo); end
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (dato_listo !== 1'b1) begin failures++; $display("FAIL release_listo: got=%b required=1", dato_listo); end
        checks++;
        if ({habilitacion_registros, error_trama, direccion_registros, datos_registros, contador_escrituras} !== '0) begin
            failures++;
            $display("FAIL release_outputs: hab=%b err=%b dir=%h dat=%h cnt=%0d required all 0",
                     habilitacion_registros, error_trama, direccion_registros, datos_registros, contador_escrituras);
        end
    endtask

    task automatic test_basic;
        send_frame(8'h00, 8'h01, 8'h00, 8'h00, 8'h0A);
        checks++;
        if (habilitacion_registros !== 1'b1) begin failures++; $display("FAIL basic_strobe: got=%b required=1", habilitacion_registros); end
        checks++;
        if (direccion_registros !== 11'h001) begin failures++; $display("FAIL basic_dir: got=%h required=001", direccion_registros); end
        checks++;
        if (datos_registros !== 21'd10) begin failures++; $display("FAIL basic_dat: got=%h required=00000a", datos_registros); end
        checks++;
        if (dato_listo !== 1'b0) begin failures++; $display("FAIL basic_listo_escribe: got=%b required=0", dato_listo); end
        @(posedge clk);
        #1;
        exp_cnt++;
        checks++;
        if (habilitacion_registros !== 1'b0) begin failures++; $display("FAIL basic_strobe_one_cycle: got=%b required=0", habilitacion_registros); end
        checks++;
        if (contador_escrituras !== 16'(exp_cnt)) begin failures++; $display("FAIL basic_count: got=%0d required=%0d", contador_escrituras, exp_cnt); end
        checks++;
        if (dato_listo !== 1'b1 || direccion_registros !== 11'h001) begin
            failures++;
            $display("FAIL basic_after: listo=%b dir=%h required listo=1 dir=001", dato_listo, direccion_registros);
        end
    endtask

    task automatic test_truncate;
        send_frame(8'h07, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        checks++;
        if (habilitacion_registros !== 1'b1 || direccion_registros !== 11'h7FF || datos_registros !== 21'h1FFFFF) begin
            failures++;
            $display("FAIL truncate: hab=%b dir=%h dat=%h required hab=1 dir=7ff dat=1fffff",
                     habilitacion_registros, direccion_registros, datos_registros);
        end
        @(posedge clk);
        #1;
        exp_cnt++;
        checks++;
        if (contador_escrituras !== 16'(exp_cnt)) begin failures++; $display("FAIL truncate_count: got=%0d required=%0d", contador_escrituras, exp_cnt); end
    endtask

    task automatic test_back_to_back;
        int s0;
        s0 = n_strobe;
        send_frame(8'h01, 8'h23, 8'h45, 8'h67, 8'h89);
        checks++;
        if (direccion_registros !== 11'h123 || datos_registros !== 21'h056789) begin
            failures++;
            $display("FAIL b2b_first: dir=%h dat=%h required dir=123 dat=056789", direccion_registros, datos_registros);
        end
        send_frame(8'h12, 8'h34, 8'h00, 8'h00, 8'hFF);
        checks++;
        if (habilitacion_registros !== 1'b1 || direccion_registros !== 11'h234 || datos_registros !== 21'h0000FF) begin
            failures++;
            $display("FAIL b2b_second: hab=%b dir=%h dat=%h required hab=1 dir=234 dat=0000ff",
                     habilitacion_registros, direccion_registros, datos_registros);
        end
        @(posedge clk);
        #1;
        exp_cnt += 2;
        checks++;
        if (n_strobe - s0 !== 2) begin failures++; $display("FAIL b2b_strobes: got=%0d required=2", n_strobe - s0); end
        checks++;
        if (sep !== NB + 1) begin failures++; $display("FAIL b2b_spacing: got=%0d required=%0d", sep, NB + 1); end
        checks++;
        if (contador_escrituras !== 16'(exp_cnt)) begin failures++; $display("FAIL b2b_count: got=%0d required=%0d", contador_escrituras, exp_cnt); end
    endtask

    task automatic test_timeout;
        int s0, e0;
        s0 = n_strobe;
        e0 = n_err;
        send_byte(8'h00);
        send_byte(8'h05);
        repeat (T - 1) @(posedge clk);
        #1;
        checks++;
        if (error_trama !== 1'b0) begin failures++; $display("FAIL timeout_early: got=%b required=0", error_trama); end
        @(posedge clk);
        #1;
        checks++;
        if (error_trama !== 1'b1 || dato_listo !== 1'b1) begin
            failures++;
            $display("FAIL timeout_pulse: err=%b listo=%b required err=1 listo=1", error_trama, dato_listo);
        end
        @(posedge clk);
        #1;
        checks++;
        if (n_err - e0 !== 1 || n_strobe !== s0) begin
            failures++;
            $display("FAIL timeout_counts: errs=%0d strobes=%0d required errs=1 strobes=0", n_err - e0, n_strobe - s0);
        end
        send_frame(8'h00, 8'h00, 8'h00, 8'h00, 8'h03);
        checks++;
        if (habilitacion_registros !== 1'b1 || direccion_registros !== 11'h000 || datos_registros !== 21'd3) begin
            failures++;
            $display("FAIL timeout_recover: hab=%b dir=%h dat=%h required hab=1 dir=000 dat=000003",
                     habilitacion_registros, direccion_registros, datos_registros);
        end
        @(posedge clk);
        #1;
        exp_cnt++;
    endtask

    task automatic test_expiry_byte;
        int e0;
        e0 = n_err;
        send_byte(8'h00);
        send_byte(8'h02);
        repeat (T - 1) @(posedge clk);
        #1;
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h05);
`ifdef MAESTRO_REGISTROS_CHECKSUM_EN
        send_byte(8'h07);
`endif
        checks++;
        if (habilitacion_registros !== 1'b1 || direccion_registros !== 11'h002 || datos_registros !== 21'd5) begin
            failures++;
            $display("FAIL expiry_byte_write: hab=%b dir=%h dat=%h required hab=1 dir=002 dat=000005",
                     habilitacion_registros, direccion_registros, datos_registros);
        end
        @(posedge clk);
        #1;
        exp_cnt++;
        checks++;
        if (n_err !== e0) begin failures++; $display("FAIL expiry_byte_err: got=%0d required=0", n_err - e0); end
        checks++;
        if (contador_escrituras !== 16'(exp_cnt)) begin failures++; $display("FAIL expiry_count: got=%0d required=%0d", contador_escrituras, exp_cnt); end
    endtask

`ifdef MAESTRO_REGISTROS_CHECKSUM_EN
    task automatic test_checksum;
        int s0;
        send_frame(8'h00, 8'h01, 8'h00, 8'h00, 8'h0A);
        checks++;
        if (habilitacion_registros !== 1'b1 || direccion_registros !== 11'h001 || datos_registros !== 21'd10) begin
            failures++;
            $display("FAIL chk_good: hab=%b dir=%h dat=%h required hab=1 dir=001 dat=00000a",
                     habilitacion_registros, direccion_registros, datos_registros);
        end
        @(posedge clk);
        #1;
        exp_cnt++;
        s0 = n_strobe;
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h0A);
        send_byte(8'h0C);
        checks++;
        if (habilitacion_registros !== 1'b0 || error_trama !== 1'b1) begin
            failures++;
            $display("FAIL chk_bad: hab=%b err=%b required hab=0 err=1", habilitacion_registros, error_trama);
        end
        @(posedge clk);
        #1;
        checks++;
        if (contador_escrituras !== 16'(exp_cnt) || n_strobe !== s0 || direccion_registros !== 11'h001 || error_trama !== 1'b0) begin
            failures++;
            $display("FAIL chk_bad_after: cnt=%0d strobes=%0d dir=%h err=%b required cnt=%0d strobes=0 dir=001 err=0",
                     contador_escrituras, n_strobe - s0, direccion_registros, error_trama, exp_cnt);
        end
    endtask
`endif

    task automatic test_reset_mid;
        int s0, e0;
        s0 = n_strobe;
        e0 = n_err;
        send_byte(8'h00);
        send_byte(8'h07);
        send_byte(8'h00);
        reset = 1'b1;
        #3;
        checks++;
        if (dato_listo !== 1'b0 || contador_escrituras !== 16'd0) begin
            failures++;
            $display("FAIL reset_mid_async: listo=%b cnt=%0d required listo=0 cnt=0", dato_listo, contador_escrituras);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (n_strobe !== s0 || n_err !== e0) begin
            failures++;
            $display("FAIL reset_mid_quiet: strobes=%0d errs=%0d required 0 and 0", n_strobe - s0, n_err - e0);
        end
        send_frame(8'h00, 8'h03, 8'h00, 8'h01, 8'h00);
        checks++;
        if (habilitacion_registros !== 1'b1 || direccion_registros !== 11'h003 || datos_registros !== 21'h000100) begin
            failures++;
            $display("FAIL reset_mid_frame: hab=%b dir=%h dat=%h required hab=1 dir=003 dat=000100",
                     habilitacion_registros, direccion_registros, datos_registros);
        end
        @(posedge clk);
        #1;
        checks++;
        if (contador_escrituras !== 16'd1) begin failures++; $display("FAIL reset_mid_count: got=%0d required=1", contador_escrituras); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_truncate();
        test_back_to_back();
        test_timeout();
        test_expiry_byte();
`ifdef MAESTRO_REGISTROS_CHECKSUM_EN
        test_checksum();
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/maestro_registros.md
Name: maestro_registros

Overview:
- Register-bus master: the write side of the configuration interface consumed by control_mascara and the other filter blocks.
- Receives a byte stream (from the UART/host bridge) over a valid/ready handshake.
- Assembles fixed-length frames into an 11-bit address and 21-bit data.
- Issues one single-cycle register write per frame on direccion_registros/datos_registros/habilitacion_registros.

Parameters:
- ANCHO_DIR, 11, register address width (bits used from the address bytes).
- ANCHO_DATO, 21, register data width (bits used from the data bytes).
- TIEMPO_ESPERA, 1000, idle cycles allowed between bytes of a partial frame before it is discarded; legal range 2..65535.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- dato_entrada  input  8  stream byte.
- dato_valido  input  1  dato_entrada is valid.
- dato_listo  output  1  block can accept a byte; transfer occurs when dato_valido && dato_listo at the rising edge.
- direccion_registros  output  ANCHO_DIR  write address.
- datos_registros  output  ANCHO_DATO  write data.
- habilitacion_registros  output  1  one-cycle write strobe.
- error_trama  output  1  one-cycle pulse: frame discarded (timeout, or checksum when enabled).
- contador_escrituras  output  16  count of writes issued; wraps at 65535 to 0.

Behaviour:
- Reset: async-clear all state. Outputs: dato_listo=0 while reset is high and 1 on the first cycle after release; direccion_registros=0; datos_registros=0; habilitacion_registros=0; error_trama=0; contador_escrituras=0; state ESPERA; byte index=0.
- Frame format, 5 bytes, MSB first:
  - B0,B1 form a 16-bit address; the low ANCHO_DIR bits are used, upper bits are ignored.
  - B2,B3,B4 form a 24-bit data word; the low ANCHO_DATO bits are used.
- States:
  - ESPERA: dato_listo=1. An accepted byte is stored as B0, index becomes 1, go to RECIBE.
  - RECIBE: dato_listo=1. Each accepted byte is stored at the current index, which then increments. Accepting the last byte (B4) goes to ESCRIBE.
  - ESCRIBE: one cycle only. dato_listo=0, habilitacion_registros=1, direccion_registros/datos_registros show the assembled frame, contador_escrituras increments. Then go to ESPERA.
- Latency: last byte accepted at edge N → strobe high for exactly the cycle after edge N+1 is not used; the strobe is high in the cycle between edges N and N+1. direccion_registros/datos_registros update at edge N and hold until the next frame's write; they never change between writes.
- The strobe is never asserted for two consecutive cycles. Minimum write spacing is 6 cycles at full stream rate.
- Timeout: an idle counter runs only in RECIBE and clears on every accepted byte. When it reaches TIEMPO_ESPERA-1 with no byte accepted: discard the partial frame, pulse error_trama for one cycle, return to ESPERA with index 0. If a byte is accepted in the expiry cycle, the byte wins and no error is raised.
- A byte presented in ESCRIBE is not accepted (dato_listo=0). The source holds it, and it is accepted on the next cycle as B0 of the next frame.
- dato_valido with dato_listo=0: no state change.
- Reset asserted mid-frame: the partial frame is lost, no strobe and no error pulse.
- dato_listo depends only on state and is registered; it has no combinational path from dato_valido.

Optional Feature:
- Macro: MAESTRO_REGISTROS_CHECKSUM_EN.
- Defined:
  - The frame is 6 bytes; B5 = XOR of B0..B4.
  - On match, ESCRIBE proceeds as above.
  - On mismatch: no strobe, counter unchanged, error_trama pulses in the cycle after B5 is accepted, return to ESPERA.
- Undefined: 5-byte frame, no check. error_trama is driven only by timeout.

Decomposition:
- Shared package (filtros_pkg): state encoding constants (ESPERA, RECIBE, ESCRIBE), BYTES_TRAMA (5 or 6, selected by the macro), and the default ANCHO_DIR/ANCHO_DATO values shared with control_mascara.
- One natural sub-module: temporizador_espera. It is the idle counter with inputs limpiar/habilitar and output expirado, reusable by other stream receivers.

Test Plan:
- Reset release → dato_listo=1, all other outputs 0. Reassert reset mid-frame after 3 bytes → no strobe; the next full frame writes normally.
- Stream 00 01 00 00 0A back-to-back → strobe one cycle after B4 with direccion_registros=1, datos_registros=10; contador_escrituras=1; dato_listo=0 during the strobe cycle.
- Stream 07 FF FF FF FF → direccion_registros=0x7FF, datos_registros=0x1FFFFF (upper bits truncated).
- Send 2 bytes, then idle for TIEMPO_ESPERA cycles → error_trama pulses once, no strobe. A following frame 00 00 00 00 03 writes address 0, data 3.
- Byte arrives exactly in the expiry cycle → accepted, no error_trama; the frame completes.
- CHECKSUM_EN: frame 00 01 00 00 0A 0B → write. Last byte changed to 0C → error_trama, no write, counter unchanged.
